// File: rtl/regfile_ctrl.sv
// regfile_ctrl: multi-cycle controller that sequences a register file and
// ALU datapath through one instruction at a time. A 16-bit instruction is
// captured into IR on an accepted start, decoded, and stepped through the
// read / execute / write-back states. All control outputs are registered:
// each edge loads the outputs that belong to the state being entered, so
// they are glitch-free Moore outputs aligned with the state register.
module regfile_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_DECODE,
    ST_WRITE_IMM,
    ST_GET_A,
    ST_GET_B,
    ST_EXEC,
    ST_WRITE_REG
  } state_t;

  // Instruction classes; ADD and AND share one path (three-operand ALU op).
  typedef enum logic [2:0] {
    K_MOV_IMM,
    K_MOV_REG,
    K_ALU3,
    K_CMP,
    K_MVN,
    K_ILLEGAL
  } kind_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctrl_t;

  state_t      state, state_d;
  logic [15:0] ir, ir_d;
  ctrl_t       ctrl;

  // Map opcode [15:13] / op [12:11] onto an instruction class.
  function automatic kind_t classify(logic [15:0] i);
    kind_t k;
    k = K_ILLEGAL;
    case (i[15:13])
      3'b110: begin
        if (i[12:11] == 2'b10)      k = K_MOV_IMM;
        else if (i[12:11] == 2'b00) k = K_MOV_REG;
        else                        k = K_ILLEGAL;
      end
      3'b101: begin
        case (i[12:11])
          2'b01:   k = K_CMP;
          2'b11:   k = K_MVN;
          default: k = K_ALU3;
        endcase
      end
      default: k = K_ILLEGAL;
    endcase
    return k;
  endfunction

  // Control word for a given state and IR; everything not named stays 0.
  function automatic ctrl_t ctrl_for(state_t st, logic [15:0] i);
    ctrl_t c;
    kind_t k;
    c      = '0;
    k      = classify(i);
    c.busy = (st != ST_WAIT);
    case (st)
      ST_DECODE: begin
        if (k == K_ILLEGAL) begin
          c.err  = 1'b1;
          c.done = 1'b1;
        end
      end
      ST_WRITE_IMM: begin
        c.write    = 1'b1;
        c.writenum = i[10:8];
        c.vsel     = 1'b1;
        c.done     = 1'b1;
      end
      ST_GET_A: begin
        c.readnum = i[10:8];
        c.loada   = 1'b1;
      end
      ST_GET_B: begin
        c.readnum = i[2:0];
        c.loadb   = 1'b1;
      end
      ST_EXEC: begin
        c.shift = i[4:3];
        if (k == K_MOV_REG) begin
          c.asel  = 1'b1;
          c.aluop = 2'b00;
        end else begin
          c.aluop = i[12:11];
        end
        if (k == K_CMP) begin
          c.loads = 1'b1;
          c.done  = 1'b1;
        end else begin
          c.loadc = 1'b1;
        end
      end
      ST_WRITE_REG: begin
        c.write    = 1'b1;
        c.writenum = i[7:5];
        c.done     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state and IR-capture logic.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    state_d = state;
    ir_d    = ir;
    case (state)
      ST_WAIT: begin
        if (start) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (classify(ir))
          K_MOV_IMM:         state_d = ST_WRITE_IMM;
          K_MOV_REG, K_MVN:  state_d = ST_GET_B;
          K_ALU3, K_CMP:     state_d = ST_GET_A;
          default:           state_d = ST_WAIT;
        endcase
      end
      ST_GET_A:     state_d = ST_GET_B;
      ST_GET_B:     state_d = ST_EXEC;
      ST_EXEC:      state_d = (classify(ir) == K_CMP) ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_IMM: state_d = ST_WAIT;
      ST_WRITE_REG: state_d = ST_WAIT;
      default:      state_d = ST_WAIT;
    endcase
  end

  // State, IR and registered control outputs; reset clears all of them at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state <= ST_WAIT;
      ir    <= '0;
      ctrl  <= '0;
    end else begin
      state <= state_d;
      ir    <= ir_d;
      ctrl  <= ctrl_for(state_d, ir_d);
    end
  end

  assign busy     = ctrl.busy;
  assign done     = ctrl.done;
  assign err      = ctrl.err;
  assign readnum  = ctrl.readnum;
  assign writenum = ctrl.writenum;
  assign write    = ctrl.write;
  assign loada    = ctrl.loada;
  assign loadb    = ctrl.loadb;
  assign loadc    = ctrl.loadc;
  assign loads    = ctrl.loads;
  assign asel     = ctrl.asel;
  assign vsel     = ctrl.vsel;
  assign shift    = ctrl.shift;
  assign ALUop    = ctrl.aluop;
  assign sximm8   = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to execute instr; sampled only in WAIT.
REQ-005 instr  input  16  instruction; latched into internal IR when start is accepted.
REQ-006 busy  output  1  high whenever state is not WAIT.
REQ-007 done  output  1  one-cycle pulse in the final state of each instruction.
REQ-008 err  output  1  one-cycle pulse when the decoded instruction is illegal.
REQ-009 readnum, writenum  output  3 each  register file read and write selects.
REQ-010 write  output  1  register file write enable.
REQ-011 loada, loadb, loadc, loads  output  1 each  datapath A, B, C and status register loads.
REQ-012 asel  output  1  forces ALU A operand to zero.
REQ-013 vsel  output  1  register file write source: 0 = datapath C, 1 = sximm8.
REQ-014 shift  output  2  shifter control.
REQ-015 ALUop  output  2  ALU operation.
REQ-016 sximm8  output  16  IR[7:0] sign-extended, continuously driven from IR.

Function
REQ-017 IR fields SHALL be: opcode [15:13], op [12:11], Rn [10:8], Rd [7:5], sh [4:3], Rm [2:0], imm8 [7:0].
REQ-018 The supported instructions SHALL be exactly these:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND Rd,Rn,Rm{,sh}
  - 101/11 MVN Rd,Rm{,sh}
  - All other opcode/op combinations are illegal.
REQ-019 The FSM states SHALL be WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG; outputs are Moore, decoded from state and IR.
REQ-020 WAIT SHALL latch instr into IR and go to DECODE when start=1; otherwise it holds. start is ignored in all other states.
REQ-021 DECODE SHALL route as follows:
  - MOV imm: to WRITE_IMM.
  - MOV reg or MVN: to GET_B.
  - ADD, CMP or AND: to GET_A.
  - Illegal: err=1 and done=1, then to WAIT.
REQ-022 WRITE_IMM SHALL drive write=1, writenum=Rn, vsel=1, done=1, then go to WAIT.
REQ-023 GET_A SHALL drive readnum=Rn, loada=1, then go to GET_B.
REQ-024 GET_B SHALL drive readnum=Rm, loadb=1, then go to EXEC.
REQ-025 EXEC SHALL drive shift=sh, and:
  - ALUop=op for opcode 101; ALUop=00 with asel=1 for MOV reg.
  - loadc=1 except for CMP.
  - For CMP: loads=1, done=1, then to WAIT. Otherwise to WRITE_REG.
REQ-026 WRITE_REG SHALL drive write=1, writenum=Rd, vsel=0, done=1, then go to WAIT.
REQ-027 Every output not named for the current state SHALL be 0; shift SHALL be 00 outside EXEC.
REQ-028 done SHALL be high in the following cycle after start is accepted (cycle 1 = DECODE):
  - Illegal: cycle 1.
  - MOV imm: cycle 2.
  - MOV reg, MVN, CMP: cycle 4.
  - ADD, AND: cycle 5.
REQ-029 Back-to-back operation SHALL be supported: start high in the cycle after done is accepted with no idle cycle beyond WAIT.
REQ-030 At most one of write, loads SHALL be high in any cycle, and write SHALL be high for exactly one cycle per register-writing instruction.

Reset
REQ-031 reset=1 SHALL immediately, without waiting for a clock edge:
  - set state to WAIT and IR to 0;
  - force all outputs to 0 (sximm8=0x0000).
REQ-032 Reset mid-instruction SHALL abort it with no write, loads or done issued afterward.
REQ-033 After reset deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-034 MOV R3,#-5: instr=0xD3FB with start pulse -> DECODE, then WRITE_IMM with write=1, writenum=3, vsel=1, sximm8=0xFFFB, done=1; busy falls the next cycle.
REQ-035 ADD R2,R1,R0 LSL: instr=0xA148 -> in order:
  - readnum=1 with loada=1
  - readnum=0 with loadb=1
  - loadc=1, shift=01, ALUop=00
  - write=1, writenum=2, vsel=0, done=1 (cycle 5)
REQ-036 CMP R5,R6: instr=0xAD06 -> loada with readnum=5, loadb with readnum=6, then loads=1 with ALUop=01 and done=1 in cycle 4; write stays 0 throughout.
REQ-037 Illegal: instr=0x0000 -> err=1 and done=1 in cycle 1, no load or write asserted; a following MOV imm executes normally.
REQ-038 ADD started, reset asserted during GET_B -> all outputs 0 asynchronously, write never asserted; start held high during busy of a later instruction is ignored (IR unchanged).
